siso_xfer_ctrl: RTL and testbench

- Sequences a serial word transfer through an external DEPTH-stage SISO shift chain (one flop per stage, shifts when enabled).
- Accepts a parallel word on a valid/ready input, drives the chain's serial input bit by bit with a shift enable, then captures the chain's serial output back into a parallel word.
- The reassembled word is presented on a valid/ready output.
- Sits between a parallel producer/consumer and the serial delay chain; used as its scheduler and as the bring-up loopback checker.

---
 rtl/siso_pkg.sv | 25 ++
 rtl/siso_chain.sv | 28 ++
 rtl/siso_xfer_ctrl.sv | 114 +++++++++++
 tb/tb_siso_xfer_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the SISO transfer controller and its delay chain.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic FILL_BIT = 1'b0;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage serial-in serial-out chain; one bit of delay per enabled clock.
// No backpressure: each stage shifts unconditionally whenever shift_en is high.
module siso_chain #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic sin,
    output logic sout
);

    logic [DEPTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
        end else if (shift_en) begin
            r_stage[0] <= sin;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign sout = r_stage[DEPTH-1];

endmodule

// File: rtl/siso_xfer_ctrl.sv
// Serialises a word through an external SISO chain and reassembles it: WIDTH+DEPTH shift cycles per word.
// DONE holds out_valid/out_data until out_ready; no new word is accepted until the result is taken.
module siso_xfer_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             sin,
    input  logic             sout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] LP_LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LP_LAST_FLUSH = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] LP_DEPTH      = CW'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_rx_cnt;
    logic [CW-1:0]    w_bit_pos;
    logic             w_accept;
    logic             w_active;
    logic             w_capture;
    logic             w_tx_bit;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_active  = (r_state == SHIFT) || (r_state == FLUSH);
    // Before DEPTH shifts sout still carries whatever the chain held, so it is dropped.
    assign w_capture = w_active && (r_cnt >= LP_DEPTH);
    assign w_rx_cnt  = r_cnt - LP_DEPTH;
    assign w_bit_pos = MSB_FIRST ? (LP_LAST_SHIFT - w_rx_cnt) : w_rx_cnt;
    assign w_tx_bit  = MSB_FIRST ? r_tx[WIDTH-1] : r_tx[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx  <= '0;
            r_rx  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_tx  <= in_data;
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == SHIFT) begin
                r_tx <= MSB_FIRST ? (r_tx << 1) : (r_tx >> 1);
            end
            for (int b = 0; b < WIDTH; b++) begin
                if (w_capture && (w_bit_pos == CW'(b))) begin
                    r_rx[b] <= sout;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = SHIFT;
            SHIFT:   if (r_cnt == LP_LAST_SHIFT) w_next = FLUSH;
            FLUSH:   if (r_cnt == LP_LAST_FLUSH) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        sin       = FILL_BIT;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SHIFT: begin
                shift_en = 1'b1;
                sin      = w_tx_bit;
            end
            FLUSH:   shift_en  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    assign out_data = r_rx;

endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// Directed bench: three controller+chain pairs (8/4 MSB-first, 8/4 LSB-first, 1/1).
module tb_siso_xfer_ctrl;

    logic clk;
    logic rst;
    logic chain_rst_n;
    int   checks;
    int   failures;

    // Pair 0: WIDTH=8 DEPTH=4 MSB_FIRST=1, chain inputs can be overridden for preloading.
    logic [7:0] in_data0;
    logic       in_valid0, in_ready0, shift_en0, sin0, sout0;
    logic [7:0] out_data0;
    logic       out_valid0, out_ready0, busy0;
    logic       frc, frc_sin;
    logic       chain_en0, chain_sin0;

    // Pair 1: WIDTH=8 DEPTH=4 MSB_FIRST=0.
    logic [7:0] in_data1;
    logic       in_valid1, in_ready1, shift_en1, sin1, sout1;
    logic [7:0] out_data1;
    logic       out_valid1, out_ready1, busy1;

    // Pair 2: WIDTH=1 DEPTH=1.
    logic [0:0] in_data2;
    logic       in_valid2, in_ready2, shift_en2, sin2, sout2;
    logic [0:0] out_data2;
    logic       out_valid2, out_ready2, busy2;

    assign chain_en0  = frc ? 1'b1 : shift_en0;
    assign chain_sin0 = frc ? frc_sin : sin0;

    siso_xfer_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .shift_en(shift_en0), .sin(sin0), .sout(sout0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0));
    siso_chain #(.DEPTH(4)) u_chain0 (
        .clk(clk), .rst(chain_rst_n), .shift_en(chain_en0), .sin(chain_sin0), .sout(sout0));

    siso_xfer_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .shift_en(shift_en1), .sin(sin1), .sout(sout1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1));
    siso_chain #(.DEPTH(4)) u_chain1 (
        .clk(clk), .rst(chain_rst_n), .shift_en(shift_en1), .sin(sin1), .sout(sout1));

    siso_xfer_ctrl #(.WIDTH(1), .DEPTH(1), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .shift_en(shift_en2), .sin(sin2), .sout(sout2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2));
    siso_chain #(.DEPTH(1)) u_chain2 (
        .clk(clk), .rst(chain_rst_n), .shift_en(shift_en2), .sin(sin2), .sout(sout2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one word on pair 0 from IDLE and returns while DONE is showing.
    // edges counts the accepting edge as edge 1.
    task automatic xfer0(input logic [7:0] d, output int edges, output int shifts,
                         output int busyc, output logic [11:0] pat);
        edges  = 0;
        shifts = 0;
        busyc  = 0;
        pat    = '0;
        in_data0  = d;
        in_valid0 = 1'b1;
        tick();
        edges     = 1;
        in_valid0 = 1'b0;
        while (!out_valid0 && edges < 40) begin
            if (shift_en0) begin
                shifts++;
                pat = {pat[10:0], sin0};
            end
            if (busy0) busyc++;
            tick();
            edges++;
        end
        if (busy0) busyc++;
    endtask

    initial begin
        int          edges, shifts, busyc, nvalid, bad_rdy;
        logic [11:0] pat;

        checks = 0;
        failures = 0;
        rst = 1'b0;
        chain_rst_n = 1'b0;
        frc = 1'b0;
        frc_sin = 1'b0;
        in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

        #3;
        chk("rst_in_ready",  {31'd0, in_ready0},  32'd1);
        chk("rst_shift_en",  {31'd0, shift_en0},  32'd0);
        chk("rst_sin",       {31'd0, sin0},       32'd0);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data0},  32'd0);
        chk("rst_busy",      {31'd0, busy0},      32'd0);
        #10;
        rst = 1'b1;
        chain_rst_n = 1'b1;
        tick();

        // Basic MSB-first transfer of 0xA5.
        chk("basic_in_ready_idle", {31'd0, in_ready0}, 32'd1);
        xfer0(8'hA5, edges, shifts, busyc, pat);
        chk("basic_out_valid", {31'd0, out_valid0}, 32'd1);
        chk("basic_out_data",  {24'd0, out_data0},  32'hA5);
        chk("basic_edges",     edges,  13);
        chk("basic_shift_cyc", shifts, 12);
        chk("basic_busy_cyc",  busyc,  13);
        chk("basic_sin_pat",   {20'd0, pat}, 32'hA50);
        tick();
        chk("basic_release_valid", {31'd0, out_valid0}, 32'd0);
        chk("basic_release_ready", {31'd0, in_ready0},  32'd1);
        chk("basic_release_busy",  {31'd0, busy0},      32'd0);

        // Back-to-back words with backpressure on the first.
        out_ready0 = 1'b0;
        in_data0   = 8'h00;
        in_valid0  = 1'b1;
        tick();
        in_data0 = 8'hFF;
        bad_rdy  = 0;
        edges    = 1;
        while (!out_valid0 && edges < 40) begin
            if (in_ready0) bad_rdy++;
            tick();
            edges++;
        end
        chk("bp_in_ready_busy", bad_rdy, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid",    {31'd0, out_valid0}, 32'd1);
            chk("bp_hold_data",     {24'd0, out_data0},  32'h00);
            chk("bp_hold_in_ready", {31'd0, in_ready0},  32'd0);
            chk("bp_hold_shift_en", {31'd0, shift_en0},  32'd0);
            tick();
        end
        out_ready0 = 1'b1;
        tick();
        chk("b2b_gap_valid",    {31'd0, out_valid0}, 32'd0);
        chk("b2b_gap_in_ready", {31'd0, in_ready0},  32'd1);
        tick();
        in_valid0 = 1'b0;
        chk("b2b_second_busy", {31'd0, busy0}, 32'd1);
        edges = 1;
        while (!out_valid0 && edges < 40) begin
            tick();
            edges++;
        end
        chk("b2b_second_valid", {31'd0, out_valid0}, 32'd1);
        chk("b2b_second_data",  {24'd0, out_data0},  32'hFF);
        tick();
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid0) nvalid++;
            tick();
        end
        chk("b2b_no_duplicate", nvalid, 0);

        // Asynchronous reset while shift count is 6.
        in_data0  = 8'h3C;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        repeat (6) tick();
        chk("mid_shift_active", {31'd0, shift_en0}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_in_ready",  {31'd0, in_ready0},  32'd1);
        chk("arst_shift_en",  {31'd0, shift_en0},  32'd0);
        chk("arst_sin",       {31'd0, sin0},       32'd0);
        chk("arst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("arst_out_data",  {24'd0, out_data0},  32'd0);
        chk("arst_busy",      {31'd0, busy0},      32'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid0}, 32'd0);
        xfer0(8'hC3, edges, shifts, busyc, pat);
        chk("post_rst_data",  {24'd0, out_data0}, 32'hC3);
        chk("post_rst_edges", edges, 13);
        tick();

        // Preload the chain with ones, then send zero.
        frc     = 1'b1;
        frc_sin = 1'b1;
        repeat (4) tick();
        frc     = 1'b0;
        frc_sin = 1'b0;
        chk("stale_chain_sout", {31'd0, sout0}, 32'd1);
        xfer0(8'h00, edges, shifts, busyc, pat);
        chk("stale_valid", {31'd0, out_valid0}, 32'd1);
        chk("stale_data",  {24'd0, out_data0},  32'h00);
        tick();

        // LSB-first ordering on pair 1.
        in_data1  = 8'h01;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        pat   = '0;
        edges = 1;
        while (!out_valid1 && edges < 40) begin
            if (shift_en1) pat = {pat[10:0], sin1};
            tick();
            edges++;
        end
        chk("lsb_sin_pat",   {20'd0, pat}, 32'h800);
        chk("lsb_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("lsb_out_data",  {24'd0, out_data1},  32'h01);
        chk("lsb_edges",     edges, 13);
        tick();

        // Minimal WIDTH=1 DEPTH=1 pair.
        in_data2  = 1'b1;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        edges = 1;
        while (!out_valid2 && edges < 40) begin
            tick();
            edges++;
        end
        chk("w1d1_edges",    edges, 3);
        chk("w1d1_out_data", {31'd0, out_data2}, 32'd1);
        tick();
        chk("w1d1_release",  {31'd0, out_valid2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
